clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
- Clock-enable controller that shares one gated clock branch between N_REQ requesters.
- Sequences the enable through off / wake / on / idle-hold phases.
- Drives the enable input of an external clock-gate cell; the gate cell is not part of this block.
- BYPASS parameter keeps the branch permanently enabled, for builds where the gated branch is a plain pass-through.

Parameters:
- N_REQ, 2: number of requesters; range 1..8.
- WAKE_CYCLES, 2: cycles clk_en is held high before the first ack; range 0..15.
- IDLE_CYCLES, 3: cycles of no request before clk_en drops; range 0..255.
- BYPASS, bit 0: 1 forces clk_en=1 and the ON state permanently.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester clock request; level, held until the requester is done.
- force_on  input  1  debug override; acts as an extra request that receives no ack.
- ack  output  N_REQ  per-requester grant; the gated clock is guaranteed running while high.
- clk_en  output  1  enable to the external clock-gate cell.
- busy  output  1  high in any state other than OFF.
- wake_cnt  output  16  count of OFF-to-WAKE transitions (see Optional Feature).

Behaviour:
- Reset (rst sampled high):
  - state=OFF, clk_en=0, ack=0, busy=0, down-counter=0, wake_cnt=0.
  - With BYPASS=1: state=ON and clk_en=1 instead.
- Reset has priority over all other events and aborts any phase on the next edge.
- Define any = |req | force_on.
- clk_en and busy are decoded from the state register (state != OFF); no combinational path from inputs.
- States and transitions:
  - OFF: if any: with WAKE_CYCLES>0, go to WAKE and load cnt=WAKE_CYCLES-1; with WAKE_CYCLES=0, go straight to ON.
  - WAKE: clk_en=1, ack=0. When cnt==0, go to ON; otherwise decrement cnt. Requests dropped during WAKE are ignored; the wake still completes.
  - ON: register ack <= req each edge. If !any, go to IDLE with cnt=IDLE_CYCLES-1, or go straight to OFF if IDLE_CYCLES=0; ack <= 0 on that same edge.
  - IDLE: clk_en=1, ack=0. If any, go to ON with no wake. Else if cnt==0, go to OFF. Else decrement cnt.
- Latency:
  - req sampled at edge e in OFF: clk_en high after e; ON after e+WAKE_CYCLES; ack high after e+WAKE_CYCLES+1.
  - ack falls one edge after its req falls.
- Simultaneous events:
  - A new req in the same cycle another drops, while in ON: state stays ON; each ack follows its own req.
  - Request arriving on the exact edge IDLE cnt reaches 0: returns to ON, not OFF.
- ack[i] is never high while its req[i] was low at the previous edge.
- Invariant: ack is never high unless clk_en is high.
- BYPASS=1: state never leaves ON; ack <= req; wake_cnt stays 0.

Optional Feature:
- Macro: CLK_GATE_WAKE_STAT_EN.
- Defined: wake_cnt increments on each OFF->WAKE or OFF->ON transition; it saturates at 16'hFFFF and resets to 0.
- Undefined: no counter register; wake_cnt is tied to 16'h0.

Decomposition:
- Package clk_gate_pkg holds:
  - state enum (OFF, WAKE, ON, IDLE), 2 bits;
  - WAKE_CNT_W=4, IDLE_CNT_W=8, STAT_W=16.
- One sub-module, clk_gate_cnt: loadable down-counter with a zero flag, shared by WAKE and IDLE (one instance, reloaded per phase).
- The stat counter stays inline under the macro.

Test Plan:
- Defaults, req=2'b01 from cycle 0 -> clk_en=1 from cycle 1; ack=2'b01 from cycle 4; busy=1 from cycle 1.
- From ON, drop req at cycle k -> ack=0 at k+1; clk_en=1 through k+3; clk_en=0 and busy=0 from cycle k+4.
- In IDLE with cnt=1, raise req[1] -> returns to ON; no WAKE phase; ack=2'b10 two edges later; clk_en never drops.
- force_on=1 alone -> clk_en=1 after WAKE_CYCLES; ack stays 2'b00. With CLK_GATE_WAKE_STAT_EN defined, wake_cnt=1.
- Assert rst for one cycle while in WAKE with req=2'b11 -> next edge OFF with clk_en=0 and ack=0; a fresh wake starts on the following edge.
- BYPASS=1, req toggled 0/1 -> clk_en=1 throughout, including during and after rst; ack follows req with a 1-cycle delay; wake_cnt=0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and widths for the clk_gate_ctrl clock-enable controller.
// Optional wake statistics are enabled with the CLK_GATE_WAKE_STAT_EN macro.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam int unsigned WAKE_CNT_W = 4;
  localparam int unsigned IDLE_CNT_W = 8;
  localparam int unsigned STAT_W     = 16;

  // One counter serves both phases, so it is sized for the longer one.
  localparam int unsigned PHASE_CNT_W = (IDLE_CNT_W > WAKE_CNT_W) ? IDLE_CNT_W : WAKE_CNT_W;

  // A phase of N cycles is timed by counting N-1 down to zero.
  function automatic logic [PHASE_CNT_W-1:0] phase_preload(input int unsigned cycles);
    if (cycles == 0) begin
      return '0;
    end
    return PHASE_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/clk_gate_cnt.sv
// Loadable down-counter with a zero flag; times the WAKE and IDLE phases.
// Decrement stops at zero so a stale dec request can never wrap.
module clk_gate_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller sharing one gated clock branch between N_REQ requesters.
// Define CLK_GATE_WAKE_STAT_EN to add the saturating wake_cnt statistic.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 3,
  parameter bit          BYPASS      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              force_on,
  output logic [N_REQ-1:0]  ack,
  output logic              clk_en,
  output logic              busy,
  output logic [STAT_W-1:0] wake_cnt
);

  localparam logic [1:0] S_OFF  = ST_OFF;
  localparam logic [1:0] S_WAKE = ST_WAKE;
  localparam logic [1:0] S_ON   = ST_ON;
  localparam logic [1:0] S_IDLE = ST_IDLE;

  localparam logic [1:0] S_RESET = BYPASS ? S_ON : S_OFF;

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [N_REQ-1:0]       ack_q;
  logic                   any;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic [PHASE_CNT_W-1:0] cnt_val;

  assign any = (|req) | force_on;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_OFF: begin
        if (any) begin
          if (WAKE_CYCLES != 0) begin
            state_d  = S_WAKE;
            cnt_load = 1'b1;
            cnt_val  = phase_preload(WAKE_CYCLES);
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_WAKE: begin
        // Requests dropped mid-wake are ignored; the wake always completes.
        if (cnt_zero) begin
          state_d = S_ON;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ON: begin
        if (!any) begin
          if (IDLE_CYCLES != 0) begin
            state_d  = S_IDLE;
            cnt_load = 1'b1;
            cnt_val  = phase_preload(IDLE_CYCLES);
          end else begin
            state_d = S_OFF;
          end
        end
      end
      S_IDLE: begin
        // A request on the same edge the hold expires wins over shutting off.
        if (any) begin
          state_d = S_ON;
        end else if (cnt_zero) begin
          state_d = S_OFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (BYPASS) begin
      state_d  = S_ON;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  clk_gate_cnt #(
    .W (PHASE_CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // ack is granted only for an edge that starts and ends in ON, so the branch
  // has been running for the whole cycle before any requester sees its grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ((state_q == S_ON) && (state_d == S_ON)) ? req : '0;
    end
  end

  assign ack    = ack_q;
  assign clk_en = BYPASS ? 1'b1 : (state_q != S_OFF);
  assign busy   = BYPASS ? 1'b1 : (state_q != S_OFF);

`ifdef CLK_GATE_WAKE_STAT_EN
  logic [STAT_W-1:0] wake_cnt_q;
  logic              wake_evt;

  assign wake_evt = (state_q == S_OFF) && (state_d != S_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      wake_cnt_q <= '0;
    end else if (wake_evt && (wake_cnt_q != '1)) begin
      wake_cnt_q <= wake_cnt_q + STAT_W'(1);
    end
  end

  assign wake_cnt = wake_cnt_q;
`else
  assign wake_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (default and BYPASS builds).
module tb_clk_gate_ctrl;

`ifdef CLK_GATE_WAKE_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic        force_on;
  logic [1:0]  ack;
  logic        clk_en;
  logic        busy;
  logic [15:0] wake_cnt;

  logic        rst_b;
  logic [1:0]  req_b;
  logic        force_on_b;
  logic [1:0]  ack_b;
  logic        clk_en_b;
  logic        busy_b;
  logic [15:0] wake_cnt_b;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_wake;

  clk_gate_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .clk_en   (clk_en),
    .busy     (busy),
    .wake_cnt (wake_cnt)
  );

  clk_gate_ctrl #(.BYPASS(1'b1)) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .req      (req_b),
    .force_on (force_on_b),
    .ack      (ack_b),
    .clk_en   (clk_en_b),
    .busy     (busy_b),
    .wake_cnt (wake_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    req = 2'b00; req_b = 2'b00; force_on = 1'b0; force_on_b = 1'b0;
    tick(); tick();
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b want 0", clk_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wake_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_wake_cnt: got %0d want 0", wake_cnt); end
    n_checks++; if (clk_en_b !== 1'b1) begin n_fail++; $display("FAIL reset_bypass_clk_en: got %b want 1", clk_en_b); end
    n_checks++; if (ack_b !== 2'b00) begin n_fail++; $display("FAIL reset_bypass_ack: got %b want 00", ack_b); end
    rst = 1'b0; rst_b = 1'b0;
    exp_wake = 16'd0;
  endtask

  // req=01 from cycle 0: clk_en/busy from cycle 1, ack=01 from cycle 4.
  task automatic test_wake();
    req = 2'b01;
    exp_wake = exp_wake + 16'd1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL wake_clk_en c%0d: got %b want 1", c, clk_en); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wake_busy c%0d: got %b want 1", c, busy); end
      n_checks++; if (ack !== ((c >= 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL wake_ack c%0d: got %b want %b", c, ack, (c >= 4) ? 2'b01 : 2'b00); end
    end
    n_checks++; if (wake_cnt !== (STAT_EN ? exp_wake : 16'h0)) begin n_fail++; $display("FAIL wake_wake_cnt: got %0d want %0d", wake_cnt, STAT_EN ? exp_wake : 16'h0); end
  endtask

  // Drop req at cycle k: ack 0 at k+1, clk_en high through k+3, off from k+4.
  task automatic test_release();
    req = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL release_ack c%0d: got %b want 00", c, ack); end
      n_checks++; if (clk_en !== (c <= 3)) begin n_fail++; $display("FAIL release_clk_en c%0d: got %b want %b", c, clk_en, (c <= 3)); end
      n_checks++; if (busy !== (c <= 3)) begin n_fail++; $display("FAIL release_busy c%0d: got %b want %b", c, busy, (c <= 3)); end
    end
  endtask

  // Re-request while IDLE holds cnt=1: back to ON with no wake phase.
  task automatic test_idle_rewake();
    req = 2'b01;
    exp_wake = exp_wake + 16'd1;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL rewake_setup_ack: got %b want 01", ack); end
    req = 2'b00;
    tick(); tick();
    req = 2'b10;
    tick();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rewake_clk_en_1: got %b want 1", clk_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rewake_ack_1: got %b want 00", ack); end
    tick();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rewake_clk_en_2: got %b want 1", clk_en); end
    n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL rewake_ack_2: got %b want 10", ack); end
    n_checks++; if (wake_cnt !== (STAT_EN ? exp_wake : 16'h0)) begin n_fail++; $display("FAIL rewake_wake_cnt: got %0d want %0d", wake_cnt, STAT_EN ? exp_wake : 16'h0); end
    req = 2'b00;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL rewake_off: got %b want 0", clk_en); end
  endtask

  // Request handover inside ON, then a request on the edge IDLE cnt is 0.
  task automatic test_back_to_back();
    req = 2'b01;
    exp_wake = exp_wake + 16'd1;
    for (int c = 1; c <= 4; c++) tick();
    req = 2'b10;
    tick();
    n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL b2b_swap_ack: got %b want 10", ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_swap_busy: got %b want 1", busy); end
    req = 2'b11;
    tick();
    n_checks++; if (ack !== 2'b11) begin n_fail++; $display("FAIL b2b_both_ack: got %b want 11", ack); end
    req = 2'b00;
    tick(); tick(); tick();
    req = 2'b01;
    tick();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL b2b_idle0_clk_en: got %b want 1", clk_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL b2b_idle0_ack: got %b want 00", ack); end
    tick();
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL b2b_idle0_ack2: got %b want 01", ack); end
    n_checks++; if (wake_cnt !== (STAT_EN ? exp_wake : 16'h0)) begin n_fail++; $display("FAIL b2b_wake_cnt: got %0d want %0d", wake_cnt, STAT_EN ? exp_wake : 16'h0); end
    req = 2'b00;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_off: got %b want 0", busy); end
  endtask

  task automatic test_force_on();
    force_on = 1'b1;
    exp_wake = exp_wake + 16'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL force_clk_en c%0d: got %b want 1", c, clk_en); end
      n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL force_ack c%0d: got %b want 00", c, ack); end
    end
    n_checks++; if (wake_cnt !== (STAT_EN ? exp_wake : 16'h0)) begin n_fail++; $display("FAIL force_wake_cnt: got %0d want %0d", wake_cnt, STAT_EN ? exp_wake : 16'h0); end
    force_on = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL force_off: got %b want 0", clk_en); end
  endtask

  // Reset mid-wake aborts to OFF; the held request starts a fresh wake.
  task automatic test_rst_wake();
    req = 2'b11;
    tick();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rstw_wake_clk_en: got %b want 1", clk_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wake = 16'd0;
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL rstw_clk_en: got %b want 0", clk_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rstw_ack: got %b want 00", ack); end
    n_checks++; if (wake_cnt !== 16'h0) begin n_fail++; $display("FAIL rstw_wake_cnt_clr: got %0d want 0", wake_cnt); end
    tick();
    exp_wake = exp_wake + 16'd1;
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rstw_rewake_clk_en: got %b want 1", clk_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rstw_rewake_ack: got %b want 00", ack); end
    tick(); tick(); tick();
    n_checks++; if (ack !== 2'b11) begin n_fail++; $display("FAIL rstw_ack_on: got %b want 11", ack); end
    n_checks++; if (wake_cnt !== (STAT_EN ? exp_wake : 16'h0)) begin n_fail++; $display("FAIL rstw_wake_cnt: got %0d want %0d", wake_cnt, STAT_EN ? exp_wake : 16'h0); end
    req = 2'b00;
    for (int c = 1; c <= 4; c++) tick();
  endtask

  task automatic test_bypass();
    logic [1:0] pattern [6];
    pattern = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      req_b = pattern[i];
      tick();
      n_checks++; if (ack_b !== pattern[i]) begin n_fail++; $display("FAIL bypass_ack i%0d: got %b want %b", i, ack_b, pattern[i]); end
      n_checks++; if (clk_en_b !== 1'b1) begin n_fail++; $display("FAIL bypass_clk_en i%0d: got %b want 1", i, clk_en_b); end
      n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL bypass_busy i%0d: got %b want 1", i, busy_b); end
    end
    req_b = 2'b11;
    rst_b = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_checks++; if (clk_en_b !== 1'b1) begin n_fail++; $display("FAIL bypass_rst_clk_en c%0d: got %b want 1", c, clk_en_b); end
      n_checks++; if (ack_b !== 2'b00) begin n_fail++; $display("FAIL bypass_rst_ack c%0d: got %b want 00", c, ack_b); end
    end
    rst_b = 1'b0;
    tick();
    n_checks++; if (ack_b !== 2'b11) begin n_fail++; $display("FAIL bypass_post_rst_ack: got %b want 11", ack_b); end
    n_checks++; if (clk_en_b !== 1'b1) begin n_fail++; $display("FAIL bypass_post_rst_clk_en: got %b want 1", clk_en_b); end
    n_checks++; if (wake_cnt_b !== 16'h0) begin n_fail++; $display("FAIL bypass_wake_cnt: got %0d want 0", wake_cnt_b); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_wake = 16'd0;
    test_reset();
    test_wake();
    test_release();
    test_idle_rewake();
    test_back_to_back();
    test_force_on();
    test_rst_wake();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
